vga_sync_decoder: RTL

//  Receive-side counterpart of the VGA h_sync/v_sync/rgb stream made by the timer/alarm displays.

---
 rtl/vga_sync_decoder_if.sv | 27 ++
 rtl/vga_sync_decoder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder_if.sv
// Pixel/sync stream, probe coordinate and recovered-timing status of vga_sync_decoder.
interface vga_sync_decoder_if;
  logic        pix_tick;
  logic        h_sync;
  logic        v_sync;
  logic [11:0] rgb;
  logic [9:0]  probe_x;
  logic [9:0]  probe_y;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        active;
  logic        locked;
  logic        frame_done;
  logic [11:0] probe_rgb;
  logic        err_hlen;
  logic        err_vlen;
  logic [15:0] frame_sig;

  modport master (
    output pix_tick, h_sync, v_sync, rgb, probe_x, probe_y,
    input  x, y, active, locked, frame_done, probe_rgb, err_hlen, err_vlen, frame_sig
  );
  modport slave (
    input  pix_tick, h_sync, v_sync, rgb, probe_x, probe_y,
    output x, y, active, locked, frame_done, probe_rgb, err_hlen, err_vlen, frame_sig
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: locks x/y to sync edges, flags bad line/frame
// lengths, captures a probe pixel. Define FRAME_SIG_EN for the per-frame CRC signature.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  vga_sync_decoder_if.slave bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_LOAD = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] V_LOAD = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam int LW = $clog2(LOCK_FRAMES + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_FRAMES);

  logic          hs_q, vs_q;
  logic [11:0]   rgb_q;
  logic [9:0]    hcnt, vcnt, hcnt_nxt, vcnt_nxt;
  logic          h_seen, v_seen;
  logic [LW-1:0] lock_cnt, lock_nxt;
  logic          locked_q, active_q, frame_done_q, err_h_q, err_v_q;
  logic [11:0]   probe_q;
  logic          h_edge, v_edge, h_bad, v_bad, any_err, h_wrap, frame_end;

  always_comb begin
    h_edge    = bus.pix_tick && (bus.h_sync == SYNC_POL) && (hs_q != SYNC_POL);
    v_edge    = bus.pix_tick && (bus.v_sync == SYNC_POL) && (vs_q != SYNC_POL);
    h_bad     = h_edge && h_seen && (hcnt != H_LOAD - 10'd1);
    // the v edge may land just before or just after the line wrap
    v_bad     = v_edge && v_seen && (vcnt != V_LOAD - 10'd1) && (vcnt != V_LOAD);
    any_err   = h_bad || v_bad;
    h_wrap    = !h_edge && (hcnt == H_LAST);
    frame_end = bus.pix_tick && h_wrap && !v_edge && (vcnt == V_LAST);
    hcnt_nxt  = h_edge ? H_LOAD : (h_wrap ? 10'd0 : hcnt + 10'd1);
    vcnt_nxt  = vcnt;
    if (v_edge)      vcnt_nxt = V_LOAD;
    else if (h_wrap) vcnt_nxt = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    lock_nxt  = lock_cnt;
    if (any_err)                              lock_nxt = '0;
    else if (v_edge && lock_cnt != LOCK_MAX)  lock_nxt = lock_cnt + 1'b1;
  end

  // Sample regs reset to the asserted level so a sync already active at release
  // is not mistaken for a fresh edge.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      hs_q         <= SYNC_POL;
      vs_q         <= SYNC_POL;
      rgb_q        <= '0;
      hcnt         <= '0;
      vcnt         <= '0;
      h_seen       <= 1'b0;
      v_seen       <= 1'b0;
      lock_cnt     <= '0;
      locked_q     <= 1'b0;
      active_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_h_q      <= 1'b0;
      err_v_q      <= 1'b0;
      probe_q      <= '0;
    end else begin
      err_h_q      <= h_bad;
      err_v_q      <= v_bad;
      frame_done_q <= frame_end && locked_q;
      if (bus.pix_tick) begin
        hs_q     <= bus.h_sync;
        vs_q     <= bus.v_sync;
        rgb_q    <= bus.rgb;
        hcnt     <= hcnt_nxt;
        vcnt     <= vcnt_nxt;
        active_q <= (hcnt_nxt < H_ACT) && (vcnt_nxt < V_ACT);
        if (h_edge) h_seen <= 1'b1;
        if (v_edge) v_seen <= 1'b1;
        lock_cnt <= lock_nxt;
        locked_q <= (lock_nxt == LOCK_MAX);
        if (active_q && hcnt == bus.probe_x && vcnt == bus.probe_y) probe_q <= rgb_q;
      end
    end
  end

  assign bus.x          = hcnt;
  assign bus.y          = vcnt;
  assign bus.active     = active_q;
  assign bus.locked     = locked_q;
  assign bus.frame_done = frame_done_q;
  assign bus.probe_rgb  = probe_q;
  assign bus.err_hlen   = err_h_q;
  assign bus.err_vlen   = err_v_q;

`ifdef FRAME_SIG_EN
  logic [15:0] sig_acc, sig_q;

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      sig_acc <= 16'hFFFF;
      sig_q   <= '0;
    end else if (bus.pix_tick) begin
      if (frame_end && locked_q) sig_q <= sig_acc;
      if ((frame_end && locked_q) || any_err)
        sig_acc <= 16'hFFFF;
      else if (active_q)
        sig_acc <= {sig_acc[14:0], 1'b0} ^ (sig_acc[15] ? 16'h1021 : 16'h0000) ^ {4'h0, rgb_q};
    end
  end

  assign bus.frame_sig = sig_q;
`else
  assign bus.frame_sig = 16'h0000;
`endif
endmodule
